// File: rtl/ql_fifo_pkg.sv
// Shared constants and helpers for the fabric-side FIFO library.
// Legal parameter ranges are enforced at elaboration by the blocks that import this package.
package ql_fifo_pkg;

    localparam int DATA_WIDTH_MIN = 1;
    localparam int DATA_WIDTH_MAX = 36;
    localparam int ADDR_WIDTH_MIN = 2;
    localparam int ADDR_WIDTH_MAX = 15;

    // One extra bit so the occupancy can represent a completely full memory.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ql_sdp_ram.sv
// Simple-dual-port RAM: one write port and one registered read port on the same clock.
// The plain array with a registered read infers block RAM when it fits, distributed memory otherwise.
module ql_sdp_ram #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register resets to zero; it holds whenever no read is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ql_sync_fifo.sv
// Single-clock FIFO over a simple-dual-port RAM with occupancy count, programmable
// almost-empty/almost-full thresholds, sticky overflow/underflow flags and a synchronous flush.
module ql_sync_fifo
    import ql_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                                  CLK_i,
    input  logic                                  RESET_i,
    input  logic                                  WEN_i,
    input  logic [DATA_WIDTH-1:0]                 WDATA_i,
    input  logic                                  REN_i,
    output logic [DATA_WIDTH-1:0]                 RDATA_o,
    input  logic                                  FLUSH_i,
    input  logic [ADDR_WIDTH-1:0]                 UPAE_i,
    input  logic [ADDR_WIDTH-1:0]                 UPAF_i,
    output logic                                  EMPTY_o,
    output logic                                  FULL_o,
    output logic                                  ALMOST_EMPTY_o,
    output logic                                  ALMOST_FULL_o,
    output logic [count_width(ADDR_WIDTH)-1:0]    COUNT_o,
    output logic                                  OVERFLOW_o,
    output logic                                  UNDERFLOW_o
);

    localparam int CW = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
        ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_param_check
        $error("ql_sync_fifo: DATA_WIDTH or ADDR_WIDTH outside the supported range");
    end

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_wen;
    logic                  ram_ren;

    // Acceptance uses the flags as they stand before the edge, so a full FIFO
    // still drains on a simultaneous request and an empty one still fills.
    assign wr_acc  = WEN_i && !FULL_o;
    assign rd_acc  = REN_i && !EMPTY_o;
    assign ram_wen = wr_acc && !FLUSH_i;
    assign ram_ren = rd_acc && !FLUSH_i;

    always_ff @(posedge CLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (FLUSH_i) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (WEN_i && FULL_o) begin
                overflow <= 1'b1;
            end
            if (REN_i && EMPTY_o) begin
                underflow <= 1'b1;
            end
        end
    end

    // Flags are pure decodes of the count register and the thresholds.
    always_comb begin
        EMPTY_o        = (count == '0);
        FULL_o         = (count == DEPTH_CNT);
        ALMOST_EMPTY_o = (count <= {1'b0, UPAE_i});
        ALMOST_FULL_o  = (count >= (DEPTH_CNT - {1'b0, UPAF_i}));
    end

    assign COUNT_o     = count;
    assign OVERFLOW_o  = overflow;
    assign UNDERFLOW_o = underflow;

    ql_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (CLK_i),
        .rst   (RESET_i),
        .wen   (ram_wen),
        .waddr (wptr),
        .wdata (WDATA_i),
        .ren   (ram_ren),
        .raddr (rptr),
        .rdata (RDATA_o)
    );

endmodule

// File: tb/tb_ql_sync_fifo.sv
// Bench for ql_sync_fifo (18-bit x 16): directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_ql_sync_fifo;

    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          CLK_i = 1'b0;
    logic          RESET_i;
    logic          WEN_i;
    logic [DW-1:0] WDATA_i;
    logic          REN_i;
    logic [DW-1:0] RDATA_o;
    logic          FLUSH_i;
    logic [AW-1:0] UPAE_i;
    logic [AW-1:0] UPAF_i;
    logic          EMPTY_o;
    logic          FULL_o;
    logic          ALMOST_EMPTY_o;
    logic          ALMOST_FULL_o;
    logic [AW:0]   COUNT_o;
    logic          OVERFLOW_o;
    logic          UNDERFLOW_o;

    ql_sync_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .CLK_i          (CLK_i),
        .RESET_i        (RESET_i),
        .WEN_i          (WEN_i),
        .WDATA_i        (WDATA_i),
        .REN_i          (REN_i),
        .RDATA_o        (RDATA_o),
        .FLUSH_i        (FLUSH_i),
        .UPAE_i         (UPAE_i),
        .UPAF_i         (UPAF_i),
        .EMPTY_o        (EMPTY_o),
        .FULL_o         (FULL_o),
        .ALMOST_EMPTY_o (ALMOST_EMPTY_o),
        .ALMOST_FULL_o  (ALMOST_FULL_o),
        .COUNT_o        (COUNT_o),
        .OVERFLOW_o     (OVERFLOW_o),
        .UNDERFLOW_o    (UNDERFLOW_o)
    );

    always #5 CLK_i = ~CLK_i;

    // Reference model: contents as a queue, plus last read word and error flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata;
    logic          m_ovf;
    logic          m_udf;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"},  32'(COUNT_o),        32'(n));
        check({tag, ".empty"},  32'(EMPTY_o),        32'(n == 0));
        check({tag, ".full"},   32'(FULL_o),         32'(n == DEPTH));
        check({tag, ".aempty"}, 32'(ALMOST_EMPTY_o), 32'(n <= int'(UPAE_i)));
        check({tag, ".afull"},  32'(ALMOST_FULL_o),  32'(n >= DEPTH - int'(UPAF_i)));
        check({tag, ".ovf"},    32'(OVERFLOW_o),     32'(m_ovf));
        check({tag, ".udf"},    32'(UNDERFLOW_o),    32'(m_udf));
        check({tag, ".rdata"},  32'(RDATA_o),        32'(m_rdata));
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // One clock of traffic: drive after the falling edge, update the model at the
    // rising edge from the pre-edge occupancy, compare shortly after.
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic f);
        bit was_full;
        bit was_empty;
        WEN_i   = w;
        WDATA_i = d;
        REN_i   = r;
        FLUSH_i = f;
        @(posedge CLK_i);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && !was_empty) m_rdata = q.pop_front();
            if (w && !was_full)  q.push_back(d);
            if (w && was_full)   m_ovf = 1'b1;
            if (r && was_empty)  m_udf = 1'b1;
        end
        #1;
        check_all(tag);
        @(negedge CLK_i);
        WEN_i   = 1'b0;
        REN_i   = 1'b0;
        FLUSH_i = 1'b0;
    endtask

    initial begin
        RESET_i = 1'b1;
        WEN_i   = 1'b0;
        WDATA_i = '0;
        REN_i   = 1'b0;
        FLUSH_i = 1'b0;
        UPAE_i  = 4'd2;
        UPAF_i  = 4'd3;
        model_reset();
        #2;
        check_all("reset");
        #1 RESET_i = 1'b0;
        @(negedge CLK_i);

        // Fill and drain
        for (int i = 1; i <= 16; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
        step("overflow", 1'b1, 18'h00011, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("underflow", 1'b0, '0, 1'b1, 1'b0);

        // Clear errors, then simultaneous requests at both boundaries
        step("flush_clr", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step("refill", 1'b1, DW'(18'h100 + i), 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 18'h3aaaa, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);
        step("empty_wr_rd", 1'b1, 18'h15555, 1'b1, 1'b0);
        step("empty_rd_next", 1'b0, '0, 1'b1, 1'b0);

        // Wrap-around at steady occupancy 5
        for (int i = 0; i < 5; i++) step("pre_wrap", 1'b1, DW'(18'h200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, DW'(18'h300 + i), 1'b1, 1'b0);

        // Flush with a coincident write at count 9, both errors set
        step("set_ovf_fill", 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step("to_full", 1'b1, DW'(18'h400 + i), 1'b0, 1'b0);
        step("set_ovf", 1'b1, 18'h3ffff, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step("to_empty", 1'b0, '0, 1'b1, 1'b0);
        step("set_udf", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step("to_nine", 1'b1, DW'(18'h500 + i), 1'b0, 1'b0);
        step("flush_wen", 1'b1, 18'h0beef, 1'b1, 1'b1);
        step("post_flush_wr", 1'b1, 18'h0cafe, 1'b0, 1'b0);
        step("post_flush_rd", 1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges at count 7
        for (int i = 0; i < 7; i++) step("to_seven", 1'b1, DW'(18'h600 + i), 1'b0, 1'b0);
        #1 RESET_i = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 RESET_i = 1'b0;
        step("post_rst_wr", 1'b1, 18'h12345, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

        // Zero thresholds: almost flags collapse to empty/full
        UPAE_i = 4'd0;
        UPAF_i = 4'd0;
        step("thr0_empty", 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step("thr0_fill", 1'b1, DW'($urandom), 1'b0, 1'b0);
        step("thr0_rd", 1'b0, '0, 1'b1, 1'b0);
        UPAF_i = 4'd15;
        step("thr_max", 1'b0, '0, 1'b0, 1'b0);

        // Random traffic with occasional threshold changes and flushes
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                UPAE_i = AW'($urandom_range(0, 15));
                UPAF_i = AW'($urandom_range(0, 15));
            end
            step("random",
                 ($urandom_range(0, 99) < 55),
                 DW'($urandom),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
